// File: rtl/safe_lock_pkg.sv
// Shared definitions for the code serializer: FSM state encoding and default code width.
package safe_lock_pkg;

    // Transmit FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } tx_state_t;

    // Default number of code bits per transfer
    localparam int unsigned CODE_W_DEF = 4;

    // Number of bits actually shifted out for a given code width
    function automatic int unsigned tx_bits(input int unsigned code_w, input bit parity_en);
        return parity_en ? code_w + 1 : code_w;
    endfunction

endpackage

// File: rtl/code_ser_tx.sv
// Parallel-to-serial code transmitter, MSB first, with an optional idle gap between bits.
// Optional feature: define CODE_SER_TX_PARITY_EN to append an even-parity bit after the code.
module code_ser_tx
    import safe_lock_pkg::*;
#(
    parameter int unsigned CODE_W  = CODE_W_DEF,
    parameter int unsigned GAP_CYC = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic              abort,
    output logic              ser_val,
    output logic              ser_data,
    output logic              busy,
    output logic              done
);

`ifdef CODE_SER_TX_PARITY_EN
    localparam int unsigned SH_W = tx_bits(CODE_W, 1'b1);
`else
    localparam int unsigned SH_W = tx_bits(CODE_W, 1'b0);
`endif
    // Counter holds up to CODE_W+1 without wrapping
    localparam int unsigned CNT_W = $clog2(CODE_W + 2);
    localparam int unsigned GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SH_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
    // Gap counter counts down to zero, so it loads one less than the gap length
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

    tx_state_t        r_state;
    tx_state_t        w_state_d;
    logic [SH_W-1:0]  r_shift;
    logic [SH_W-1:0]  w_shift_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] w_gap_d;
    logic [SH_W-1:0]  w_load;
    logic             w_accept;

    logic             r_ser_val;
    logic             r_ser_data;
    logic             r_busy;
    logic             r_done;

`ifdef CODE_SER_TX_PARITY_EN
    // Even parity: the appended bit makes the total count of ones even
    assign w_load = {code_in, ^code_in};
`else
    assign w_load = code_in;
`endif

    assign code_ready = (r_state == IDLE) && !abort;
    assign w_accept   = code_valid && code_ready;

    // Next-state, shifter and counter logic
    always_comb begin
        w_state_d = r_state;
        w_shift_d = r_shift;
        w_cnt_d   = r_cnt;
        w_gap_d   = r_gap;

        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_d = SEND;
                    w_shift_d = w_load;
                    w_cnt_d   = CNT_LOAD;
                end
            end
            SEND: begin
                w_shift_d = r_shift << 1;
                w_cnt_d   = r_cnt - 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state_d = DONE;
                end else if (GAP_CYC == 0) begin
                    w_state_d = SEND;
                end else begin
                    w_state_d = GAP;
                    w_gap_d   = GAP_LOAD;
                end
            end
            GAP: begin
                if (r_gap == '0) begin
                    w_state_d = SEND;
                end else begin
                    w_gap_d = r_gap - 1'b1;
                end
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        // Abort drops the partial code; in DONE it changes nothing since IDLE is next anyway
        if (abort && (r_state != IDLE)) begin
            w_state_d = IDLE;
            w_shift_d = '0;
            w_cnt_d   = '0;
            w_gap_d   = '0;
        end
    end

    // State, shifter and counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_d;
            r_shift <= w_shift_d;
            r_cnt   <= w_cnt_d;
            r_gap   <= w_gap_d;
        end
    end

    // Registered outputs derived from the state being entered; the bit sent is the MSB
    // of the shifter value that SEND will hold
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ser_val  <= 1'b0;
            r_ser_data <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_ser_val  <= (w_state_d == SEND);
            r_ser_data <= (w_state_d == SEND) && w_shift_d[SH_W-1];
            r_busy     <= (w_state_d != IDLE);
            r_done     <= (w_state_d == DONE);
        end
    end

    assign ser_val  = r_ser_val;
    assign ser_data = r_ser_data;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_code_ser_tx.sv
// Scoreboard bench for code_ser_tx: one instance with GAP_CYC=1, one with GAP_CYC=0.
module tb_code_ser_tx;

    localparam int unsigned CW = 4;
`ifdef CODE_SER_TX_PARITY_EN
    localparam int NB = CW + 1;
`else
    localparam int NB = CW;
`endif

    typedef struct {
        logic data;
        int   cyc;
    } exp_t;

    exp_t bit_q[$];
    int   done_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic          clk        = 1'b0;
    logic          rstn       = 1'b0;
    logic [CW-1:0] code_in    = '0;
    logic          code_valid = 1'b0;
    logic          abort      = 1'b0;
    logic          sel        = 1'b0;  // 0: gap-1 instance, 1: gap-0 instance

    logic rdy1, val1, dat1, busy1, done1;
    logic rdy0, val0, dat0, busy0, done0;
    logic m_val, m_dat, m_done;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    code_ser_tx #(.CODE_W(CW), .GAP_CYC(1)) u_dut1 (
        .clk        (clk),
        .rstn       (rstn),
        .code_in    (code_in),
        .code_valid (code_valid & ~sel),
        .code_ready (rdy1),
        .abort      (abort & ~sel),
        .ser_val    (val1),
        .ser_data   (dat1),
        .busy       (busy1),
        .done       (done1)
    );

    code_ser_tx #(.CODE_W(CW), .GAP_CYC(0)) u_dut0 (
        .clk        (clk),
        .rstn       (rstn),
        .code_in    (code_in),
        .code_valid (code_valid & sel),
        .code_ready (rdy0),
        .abort      (abort & sel),
        .ser_val    (val0),
        .ser_data   (dat0),
        .busy       (busy0),
        .done       (done0)
    );

    assign m_val  = sel ? val0 : val1;
    assign m_dat  = sel ? dat0 : dat1;
    assign m_done = sel ? done0 : done1;

    function automatic logic exp_bit(input logic [CW-1:0] c, input int k);
        if (k < CW) return c[CW-1-k];
        return ^c;
    endfunction

    // Push the first nbits expected bits of a code accepted in cycle t, plus optionally its done
    task automatic push_exp(input logic [CW-1:0] c, input int t, input int g, input int nbits,
                            input bit with_done);
        for (int k = 0; k < nbits; k++) begin
            exp_t e;
            e.data = exp_bit(c, k);
            e.cyc  = t + 1 + k * (g + 1);
            bit_q.push_back(e);
        end
        if (with_done) done_q.push_back(t + 1 + (NB - 1) * (g + 1) + 1);
    endtask

    task automatic check(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: pops expected bits/done pulses whenever the DUT presents them
    always @(negedge clk) begin
        if (!m_val) begin
            checks++;
            if (m_dat !== 1'b0) begin
                errors++;
                $display("FAIL idle_data: got %b, required 0 (cycle %0d)", m_dat, cyc);
            end
        end else if (bit_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bit: got ser_val=1 data=%b, required none (cycle %0d)",
                     m_dat, cyc);
        end else begin
            exp_t e;
            e = bit_q.pop_front();
            checks++;
            if (m_dat !== e.data || cyc != e.cyc) begin
                errors++;
                $display("FAIL ser_bit: got data=%b at cycle %0d, required data=%b at cycle %0d",
                         m_dat, cyc, e.data, e.cyc);
            end
        end
        if (m_done === 1'b1) begin
            int ed;
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required none", cyc);
            end else begin
                ed = done_q.pop_front();
                if (cyc != ed) begin
                    errors++;
                    $display("FAIL done_cycle: got cycle %0d, required cycle %0d", cyc, ed);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int t2;
        int tdone;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_ser_val", val1, 1'b0);
        check("reset_ser_data", dat1, 1'b0);
        check("reset_busy", busy1, 1'b0);
        check("reset_done", done1, 1'b0);
        check("reset_ready", rdy1, 1'b1);
        rstn = 1'b1;
        @(negedge clk);

        // Basic transfer with gap: 1011
        code_in = 4'b1011;
        code_valid = 1'b1;
        #1 check("a_ready", rdy1, 1'b1);
        t = cyc;
        push_exp(4'b1011, t, 1, NB, 1'b1);
        @(posedge clk);
        #1 code_valid = 1'b0;
        code_in = 4'b0100;
        tdone = t + 1 + (NB - 1) * 2 + 1;
        wait_cyc(t + 2);
        check("a_gap_busy", busy1, 1'b1);
        check("a_gap_ready", rdy1, 1'b0);
        wait_cyc(tdone);
        check("a_done_ready", rdy1, 1'b0);
        @(negedge clk);
        check("a_after_ready", rdy1, 1'b1);
        check("a_after_busy", busy1, 1'b0);

        // Back-to-back bits: 0110 on the gap-0 instance
        sel = 1'b1;
        @(negedge clk);
        code_in = 4'b0110;
        code_valid = 1'b1;
        #1 check("b_ready", rdy0, 1'b1);
        t = cyc;
        push_exp(4'b0110, t, 0, NB, 1'b1);
        @(posedge clk);
        #1 code_valid = 1'b0;
        wait_cyc(t + NB + 1);
        check("b_done_busy", busy0, 1'b1);
        @(negedge clk);
        check("b_after_ready", rdy0, 1'b1);
        @(negedge clk);
        sel = 1'b0;
        @(negedge clk);

        // Abort during the second bit
        code_in = 4'b1011;
        code_valid = 1'b1;
        #1 t = cyc;
        push_exp(4'b1011, t, 1, 2, 1'b0);
        @(posedge clk);
        #1 code_valid = 1'b0;
        wait_cyc(t + 3);
        abort = 1'b1;
        #1 check("c_abort_ready", rdy1, 1'b0);
        @(negedge clk);
        abort = 1'b0;
        check("c_val_after_abort", val1, 1'b0);
        check("c_done_after_abort", done1, 1'b0);
        @(negedge clk);
        check("c_busy_after_abort", busy1, 1'b0);
        check("c_ready_after_abort", rdy1, 1'b1);
        repeat (8) @(negedge clk);

        // Abort together with valid in IDLE: no accept
        code_in = 4'b1111;
        code_valid = 1'b1;
        abort = 1'b1;
        #1 check("d_ready_abort", rdy1, 1'b0);
        @(posedge clk);
        #1 code_valid = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("d_busy", busy1, 1'b0);

        // Valid held with changing code: second accept only after done
        code_in = 4'b1001;
        code_valid = 1'b1;
        #1 check("e_ready", rdy1, 1'b1);
        t = cyc;
        push_exp(4'b1001, t, 1, NB, 1'b1);
        tdone = t + 1 + (NB - 1) * 2 + 1;
        @(posedge clk);
        while (cyc < tdone) begin
            @(negedge clk);
            code_in = CW'(cyc * 5 + 3);
            #1 check("e_busy_ready", rdy1, 1'b0);
        end
        @(negedge clk);
        code_in = 4'b0111;
        #1 check("e_second_ready", rdy1, 1'b1);
        t2 = cyc;
        push_exp(4'b0111, t2, 1, NB, 1'b1);
        @(posedge clk);
        #1 code_valid = 1'b0;
        wait_cyc(t2 + 1 + (NB - 1) * 2 + 2);
        check("e_end_ready", rdy1, 1'b1);

        // Reset during GAP
        @(negedge clk);
        code_in = 4'b1101;
        code_valid = 1'b1;
        #1 t = cyc;
        push_exp(4'b1101, t, 1, 1, 1'b0);
        @(posedge clk);
        #1 code_valid = 1'b0;
        wait_cyc(t + 2);
        rstn = 1'b0;
        #1;
        check("f_rst_val", val1, 1'b0);
        check("f_rst_data", dat1, 1'b0);
        check("f_rst_busy", busy1, 1'b0);
        check("f_rst_done", done1, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("f_rel_ready", rdy1, 1'b1);
        check("f_rel_busy", busy1, 1'b0);

        // Normal transfer after reset
        code_in = 4'b1011;
        code_valid = 1'b1;
        #1 t = cyc;
        push_exp(4'b1011, t, 1, NB, 1'b1);
        @(posedge clk);
        #1 code_valid = 1'b0;
        wait_cyc(t + 1 + (NB - 1) * 2 + 3);

        check("bits_drained", bit_q.size() == 0, 1'b1);
        check("dones_drained", done_q.size() == 0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/code_ser_tx.md
CODE_SER_TX -- requirements
Module: code_ser_tx

Interface
REQ-001 SHALL have parameter CODE_W, default 4, meaning the number of code bits serialized per transfer (minimum 1).
REQ-002 SHALL have parameter GAP_CYC, default 1, meaning the number of idle cycles (ser_val low) inserted between consecutive bits (0 allowed).
REQ-003 SHALL have port clk  input  1  system clock, all logic on the rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port code_in  input  CODE_W  parallel code to send, MSB sent first.
REQ-006 SHALL have port code_valid  input  1  code_in is valid.
REQ-007 SHALL have port code_ready  output  1  block accepts code_in this cycle.
REQ-008 SHALL have port abort  input  1  synchronous cancel of the transfer in progress.
REQ-009 SHALL have port ser_val  output  1  ser_data is valid this cycle.
REQ-010 SHALL have port ser_data  output  1  serial code bit.
REQ-011 SHALL have port busy  output  1  transfer in progress (any state except IDLE).
REQ-012 SHALL have port done  output  1  one-cycle pulse after the last bit is sent.

Function
REQ-013 SHALL implement the FSM states IDLE, SEND, GAP and DONE.
REQ-014 code_ready SHALL equal (state==IDLE && !abort), as combinational logic.
REQ-015 Accept SHALL occur when code_valid && code_ready; at accept, code_in latches into a shift register and the bit counter loads the number of bits to send.
REQ-016 State SHALL move IDLE->SEND on accept, with no other IDLE exit.
REQ-017 ser_val, ser_data, busy and done SHALL be registered; the first bit appears on ser_val/ser_data in the cycle after accept.
REQ-018 In SEND, ser_val SHALL be 1 for exactly one cycle, ser_data = current MSB; the shifter shifts left and the counter decrements.
REQ-019 After SEND, if bits remain and GAP_CYC>0, the FSM SHALL go to GAP for exactly GAP_CYC cycles with ser_val=0, then return to SEND.
REQ-020 After SEND, if bits remain and GAP_CYC==0, the next SEND SHALL follow directly, giving back-to-back bits.
REQ-021 After the last SEND, the FSM SHALL go to DONE with no trailing gap; done=1 for one cycle, then IDLE.
REQ-022 ser_data SHALL be 0 whenever ser_val=0.
REQ-023 code_valid while busy SHALL be ignored; code_in changes after accept SHALL have no effect.
REQ-024 abort=1 in any non-IDLE state SHALL force IDLE next cycle with ser_val=0 and done=0; a partial code is not completed.
REQ-025 abort=1 with code_valid=1 in IDLE SHALL result in no accept.
REQ-026 abort=1 in DONE SHALL suppress nothing: done is already asserted and the FSM returns to IDLE.
REQ-027 The counter width SHALL be $clog2(CODE_W+2), the gap counter width $clog2(GAP_CYC+1) with a minimum of 1, and no counter wrap is permitted.

Reset
REQ-028 Asserting rstn low SHALL asynchronously force IDLE with ser_val=0, ser_data=0, busy=0, done=0, and the shifter and counters at 0.
REQ-029 Reset mid-transfer SHALL drop the transfer; after release, the block idles with code_ready=1.

Configuration
REQ-030 With macro CODE_SER_TX_PARITY_EN defined, one extra bit SHALL be sent after the code bit (XOR of all code bits, even parity), preceded by the normal gap.
REQ-031 Without CODE_SER_TX_PARITY_EN, exactly CODE_W bits SHALL be sent; no parity logic exists.

Structure
REQ-032 The shared package safe_lock_pkg SHALL hold the tx_state_t enum (IDLE, SEND, GAP, DONE) and the CODE_W_DEF=4 constant.
REQ-033 The design SHALL be a single module with no sub-module; the FSM, shifter and counters are inline.

Verification
REQ-034 SHALL cover: CODE_W=4, GAP_CYC=1, code 4'b1011 accepted at cycle t -> ser_val high at t+1,t+3,t+5,t+7 with ser_data 1,0,1,1; done at t+8; code_ready at t+9.
REQ-035 SHALL cover: GAP_CYC=0, code 4'b0110 -> ser_val high t+1..t+4, data 0,1,1,0; done at t+5.
REQ-036 SHALL cover: abort at the cycle of the second bit -> ser_val=0 from the next cycle, no done pulse, and busy=0 one cycle later.
REQ-037 SHALL cover: code_valid held high with changing code_in during a transfer -> sent bits match the latched code, and a second accept happens only after done.
REQ-038 SHALL cover: rstn low during the GAP state -> outputs 0 immediately and IDLE after release.
REQ-039 SHALL cover: with CODE_SER_TX_PARITY_EN, code 4'b1011 -> a fifth bit of 1 at t+9 and done at t+10.
